// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I control pipeline.
// Holds opcode/func3 constants, the ResultSrc and pc_src encodings, and the
// packed per-stage control word carried from EX through WB.
package pipe_pkg;

  // Register-index width used by the control word.
  localparam int REG_AW_PKG = 5;

  // Major opcodes, kept here so decoder-side code shares one definition.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Branch conditions selected by func3.
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // ResultSrc: where the WB value comes from.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_t;

  // Next-PC selection.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pc_src_t;

  // Control word held by each of the E, M and W stage registers.
  typedef struct packed {
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic                  jump;
    logic                  branch;
    logic                  jalr;
    logic [1:0]            result_src;
    logic [2:0]            alu_control;
    logic [2:0]            func3;
    logic [REG_AW_PKG-1:0] rd;
    logic                  valid;
  } ctrl_t;

  // A bubble is the all-zero word: not valid, no writes, no control flow.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // Evaluate the conditional-branch outcome for a func3 and the EX flags.
  function automatic logic branch_cond(input logic [2:0] func3,
                                       input logic       zero,
                                       input logic       lt);
    logic taken;
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational control-flow resolution for the EX stage.
// Ports:
//   valid       in  EX stage holds a real instruction
//   branch      in  conditional branch
//   jump        in  jal
//   jalr        in  jalr
//   func3       in  branch condition select
//   alu_zero    in  EX ALU result == 0
//   alu_lt      in  EX ALU less-than outcome
//   pc_src      out 00 pc+4, 01 pc+imm, 10 ALU result
module branch_resolve
  import pipe_pkg::*;
(
  input  logic       valid,
  input  logic       branch,
  input  logic       jump,
  input  logic       jalr,
  input  logic [2:0] func3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  output logic [1:0] pc_src
);

  always_comb begin
    pc_src = PC_PLUS4;
    if (valid) begin
      // jalr wins over jump/branch so a malformed word never picks pc+imm.
      if (jalr) begin
        pc_src = PC_ALU;
      end else if (jump || (branch && branch_cond(func3, alu_zero, alu_lt))) begin
        pc_src = PC_TARGET;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline for a 5-stage RV32I core.
// Carries the decode-stage control word through EX, MEM and WB, resolves
// branch/jal/jalr in EX, and generates load-use stalls, IF/ID flushes and
// EX bubbles. A data-memory wait freezes every stage.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mem_wait              global freeze from data memory
//   *_d                   controller outputs and register indices at decode
//   alu_zero_e, alu_lt_e  EX ALU flags for branch evaluation
//   alu_src_e, alu_control_e, rd_e       registered EX controls
//   pc_src_e, stall_f, stall_d, flush_d  combinational hazard/redirect
//   mem_write_m, reg_write_m, result_src_m, rd_m  registered MEM controls
//   reg_write_w, result_src_w, rd_w               registered WB controls
module ctrl_pipe
  import pipe_pkg::*;
#(
  parameter int         REG_AW      = 5,
  parameter logic [1:0] RESULT_LOAD = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_wait,
  input  logic              mem_write_d,
  input  logic              alu_src_d,
  input  logic              reg_write_d,
  input  logic              jump_d,
  input  logic              branch_d,
  input  logic              jalr_d,
  input  logic [1:0]        result_src_d,
  input  logic [2:0]        alu_control_d,
  input  logic [2:0]        func3_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              alu_zero_e,
  input  logic              alu_lt_e,
  output logic              alu_src_e,
  output logic [2:0]        alu_control_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [1:0]        pc_src_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              mem_write_m,
  output logic              reg_write_m,
  output logic [1:0]        result_src_m,
  output logic [REG_AW-1:0] rd_m,
  output logic              reg_write_w,
  output logic [1:0]        result_src_w,
  output logic [REG_AW-1:0] rd_w
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_p0;  // EX
  ctrl_t ctrl_p1;  // MEM
  ctrl_t ctrl_p2;  // WB

  logic taken_e;
  logic lu;

  // Decode: pack the controller outputs into a valid control word.
  always_comb begin
    ctrl_d             = CTRL_BUBBLE;
    ctrl_d.mem_write   = mem_write_d;
    ctrl_d.alu_src     = alu_src_d;
    ctrl_d.reg_write   = reg_write_d;
    ctrl_d.jump        = jump_d;
    ctrl_d.branch      = branch_d;
    ctrl_d.jalr        = jalr_d;
    ctrl_d.result_src  = result_src_d;
    ctrl_d.alu_control = alu_control_d;
    ctrl_d.func3       = func3_d;
    ctrl_d.rd          = rd_d;
    ctrl_d.valid       = 1'b1;
  end

  // EX: control-flow resolution and hazard detection.
  branch_resolve u_branch_resolve (
    .valid    (ctrl_p0.valid),
    .branch   (ctrl_p0.branch),
    .jump     (ctrl_p0.jump),
    .jalr     (ctrl_p0.jalr),
    .func3    (ctrl_p0.func3),
    .alu_zero (alu_zero_e),
    .alu_lt   (alu_lt_e),
    .pc_src   (pc_src_e)
  );

  assign taken_e = (pc_src_e != PC_PLUS4);

  // rs2 is compared even for formats without rs2; the extra stall is harmless.
  assign lu = ctrl_p0.valid && ctrl_p0.reg_write &&
              (ctrl_p0.result_src == RESULT_LOAD) &&
              (ctrl_p0.rd != '0) &&
              ((ctrl_p0.rd == rs1_d) || (ctrl_p0.rd == rs2_d));

  // A freeze holds fetch/decode and defers any redirect until it lifts;
  // a redirect overrides a load-use stall because the D instruction dies.
  assign stall_f = mem_wait | (lu & ~taken_e);
  assign stall_d = mem_wait | (lu & ~taken_e);
  assign flush_d = ~mem_wait & taken_e;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_p0 <= CTRL_BUBBLE;
      ctrl_p1 <= CTRL_BUBBLE;
      ctrl_p2 <= CTRL_BUBBLE;
    end else if (!mem_wait) begin
      ctrl_p0 <= (lu || taken_e) ? CTRL_BUBBLE : ctrl_d;
      // MEM: advance EX word.
      ctrl_p1 <= ctrl_p0;
      // WB: advance MEM word.
      ctrl_p2 <= ctrl_p1;
    end
  end

  assign alu_src_e     = ctrl_p0.alu_src;
  assign alu_control_e = ctrl_p0.alu_control;
  assign rd_e          = ctrl_p0.rd;

  assign mem_write_m   = ctrl_p1.mem_write;
  assign reg_write_m   = ctrl_p1.reg_write;
  assign result_src_m  = ctrl_p1.result_src;
  assign rd_m          = ctrl_p1.rd;

  assign reg_write_w   = ctrl_p2.reg_write;
  assign result_src_w  = ctrl_p2.result_src;
  assign rd_w          = ctrl_p2.rd;

  // Later stages carry the full word for simplicity; fold the fields they
  // never drive out into one sink.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{ctrl_p1, ctrl_p2};

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_wait;
  logic       mem_write_d, alu_src_d, reg_write_d, jump_d, branch_d, jalr_d;
  logic [1:0] result_src_d;
  logic [2:0] alu_control_d, func3_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       alu_zero_e, alu_lt_e;
  logic       alu_src_e;
  logic [2:0] alu_control_e;
  logic [4:0] rd_e;
  logic [1:0] pc_src_e;
  logic       stall_f, stall_d, flush_d;
  logic       mem_write_m, reg_write_m;
  logic [1:0] result_src_m;
  logic [4:0] rd_m;
  logic       reg_write_w;
  logic [1:0] result_src_w;
  logic [4:0] rd_w;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .mem_wait(mem_wait),
    .mem_write_d(mem_write_d), .alu_src_d(alu_src_d), .reg_write_d(reg_write_d),
    .jump_d(jump_d), .branch_d(branch_d), .jalr_d(jalr_d),
    .result_src_d(result_src_d), .alu_control_d(alu_control_d), .func3_d(func3_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alu_zero_e(alu_zero_e), .alu_lt_e(alu_lt_e),
    .alu_src_e(alu_src_e), .alu_control_e(alu_control_e), .rd_e(rd_e),
    .pc_src_e(pc_src_e), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .mem_write_m(mem_write_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .rd_m(rd_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // An instruction record as it sits in one of the three slots.
  typedef struct {
    bit       v;
    bit       mw, as, rw, j, b, jr;
    bit [1:0] rs;
    bit [2:0] ac, f3;
    bit [4:0] rd;
  } instr_t;

  instr_t slot[3];   // 0 = EX, 1 = MEM, 2 = WB
  bit     started = 0;

  function automatic instr_t empty_slot();
    instr_t x;
    x = '{v:0, mw:0, as:0, rw:0, j:0, b:0, jr:0, rs:0, ac:0, f3:0, rd:0};
    return x;
  endfunction

  function automatic instr_t decoded();
    instr_t x;
    x = '{v:1, mw:mem_write_d, as:alu_src_d, rw:reg_write_d, j:jump_d,
          b:branch_d, jr:jalr_d, rs:result_src_d, ac:alu_control_d,
          f3:func3_d, rd:rd_d};
    return x;
  endfunction

  // Where the next PC comes from, from the ISA meaning of the EX instruction.
  function automatic int next_pc_kind(instr_t e, bit z, bit lt);
    bit cond;
    if (!e.v) return 0;
    if (e.jr) return 2;
    if (e.j) return 1;
    if (e.b) begin
      cond = (e.f3 == 0) ? z : (e.f3 == 1) ? !z :
             (e.f3 == 4) ? lt : (e.f3 == 5) ? !lt : 0;
      return cond ? 1 : 0;
    end
    return 0;
  endfunction

  function automatic bit load_use(instr_t e);
    return e.v && e.rw && e.rs == 2'b01 && e.rd != 0 &&
           (e.rd == rs1_d || e.rd == rs2_d);
  endfunction

  always @(posedge clk) begin
    bit redirect, hz;
    started = 1;
    redirect = next_pc_kind(slot[0], alu_zero_e, alu_lt_e) != 0;
    hz = load_use(slot[0]);
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) slot[i] = empty_slot();
    end else if (!mem_wait) begin
      slot[2] = slot[1];
      slot[1] = slot[0];
      slot[0] = (redirect || hz) ? empty_slot() : decoded();
    end
  end

  // Single compare process: every negedge once the pipe has seen a clock.
  always @(negedge clk) begin
    int pk;
    bit hz, red;
    if (started) begin
      pk  = next_pc_kind(slot[0], alu_zero_e, alu_lt_e);
      red = pk != 0;
      hz  = load_use(slot[0]);
      chk("alu_src_e", alu_src_e, slot[0].as);
      chk("alu_control_e", alu_control_e, slot[0].ac);
      chk("rd_e", rd_e, slot[0].rd);
      chk("pc_src_e", pc_src_e, pk);
      chk("stall_f", stall_f, mem_wait || (hz && !red));
      chk("stall_d", stall_d, mem_wait || (hz && !red));
      chk("flush_d", flush_d, !mem_wait && red);
      chk("mem_write_m", mem_write_m, slot[1].mw);
      chk("reg_write_m", reg_write_m, slot[1].rw);
      chk("result_src_m", result_src_m, slot[1].rs);
      chk("rd_m", rd_m, slot[1].rd);
      chk("reg_write_w", reg_write_w, slot[2].rw);
      chk("result_src_w", result_src_w, slot[2].rs);
      chk("rd_w", rd_w, slot[2].rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_d(input bit mw, as, rw, j, b, jr, input bit [1:0] rs,
                       input bit [2:0] ac, f3, input bit [4:0] r1, r2, rd);
    mem_write_d = mw; alu_src_d = as; reg_write_d = rw; jump_d = j;
    branch_d = b; jalr_d = jr; result_src_d = rs; alu_control_d = ac;
    func3_d = f3; rs1_d = r1; rs2_d = r2; rd_d = rd;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; mem_wait = 0; alu_zero_e = 0; alu_lt_e = 0;
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b010, 3'b000, 5'd1, 5'd2, 5'd4);
    step(); step();
    #1;
    chk("rst reg_write_m", reg_write_m, 0);
    chk("rst reg_write_w", reg_write_w, 0);
    chk("rst rd_e", rd_e, 0);

    // Straight-line add x3
    rst_n = 1;
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b010, 3'b000, 5'd1, 5'd2, 5'd3);
    step(); nop(); #1;
    chk("add alu_control_e", alu_control_e, 3'b010);
    chk("add rd_e", rd_e, 3);
    step(); #1;
    chk("add rd_m", rd_m, 3);
    step(); #1;
    chk("add reg_write_w", reg_write_w, 1);
    chk("add rd_w", rd_w, 3);

    // Load-use: lw x5 then add x6, x5
    set_d(0, 1, 1, 0, 0, 0, 2'b01, 3'b000, 3'b010, 5'd1, 5'd0, 5'd5);
    step();
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd5, 5'd2, 5'd6);
    #1;
    chk("lu stall_f", stall_f, 1);
    chk("lu stall_d", stall_d, 1);
    step(); #1;
    chk("lu bubble alu_src_e", alu_src_e, 0);
    chk("lu bubble rd_e", rd_e, 0);
    chk("lu stall released", stall_f, 0);
    step(); #1;
    chk("lu dependent rd_e", rd_e, 6);
    nop();

    // beq taken
    set_d(0, 0, 0, 0, 1, 0, 2'b00, 3'b001, 3'b000, 5'd1, 5'd2, 5'd0);
    step();
    alu_zero_e = 1;
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd1, 5'd2, 5'd7);
    #1;
    chk("beq pc_src", pc_src_e, 1);
    chk("beq flush_d", flush_d, 1);
    chk("beq stall_d", stall_d, 0);
    step(); #1;
    chk("beq bubble rd_e", rd_e, 0);
    chk("beq bubble pc_src", pc_src_e, 0);

    // bne not taken with zero
    set_d(0, 0, 0, 0, 1, 0, 2'b00, 3'b001, 3'b001, 5'd1, 5'd2, 5'd0);
    step(); nop(); #1;
    chk("bne pc_src", pc_src_e, 0);
    chk("bne flush_d", flush_d, 0);

    // bge taken with lt=0
    set_d(0, 0, 0, 0, 1, 0, 2'b00, 3'b001, 3'b101, 5'd1, 5'd2, 5'd0);
    step(); alu_lt_e = 0; nop(); #1;
    chk("bge pc_src", pc_src_e, 1);
    step();

    // jalr whose word also marks a load, with a dependent instruction in D
    set_d(0, 1, 1, 0, 0, 1, 2'b01, 3'b000, 3'b000, 5'd1, 5'd0, 5'd5);
    step();
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd5, 5'd0, 5'd8);
    #1;
    chk("jalr pc_src", pc_src_e, 2);
    chk("jalr flush_d", flush_d, 1);
    chk("jalr stall_d", stall_d, 0);
    step(); #1;
    chk("jalr bubble rd_e", rd_e, 0);

    // Freeze mid-stream
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd1, 5'd2, 5'd9);
    step();
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd1, 5'd2, 5'd10);
    step();
    set_d(0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 3'b000, 5'd1, 5'd2, 5'd11);
    mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz stall_f", stall_f, 1);
      chk("frz flush_d", flush_d, 0);
      chk("frz rd_e", rd_e, 10);
      chk("frz rd_m", rd_m, 9);
      step();
    end
    mem_wait = 0;
    #1;
    chk("frz held rd_e", rd_e, 10);
    step(); nop(); #1;
    chk("resume rd_w 9", rd_w, 9);
    step(); #1;
    chk("resume rd_w 10", rd_w, 10);
    step(); #1;
    chk("resume rd_w 11", rd_w, 11);

    // Randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      mem_wait    = ($urandom_range(0, 7) == 0);
      alu_zero_e  = $urandom_range(0, 1);
      alu_lt_e    = $urandom_range(0, 1);
      set_d($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 11) == 0), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      step();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
